// File: rtl/mips_regfile_param.sv
// Parametrised MIPS register file: two combinational read ports, one write port, sequential clear engine.
// Define MIPS_REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module mips_regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_reg_1,
    input  logic [ADDR_W-1:0] read_reg_2,
    output logic [DATA_W-1:0] read_data_1,
    output logic [DATA_W-1:0] read_data_2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              signal_reg_write,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              wr_en;

    // Writes only land in IDLE; the hardwired zero entry never takes one.
    assign wr_en = signal_reg_write && (state_q == S_IDLE) &&
                   !((ZERO_REG != 0) && (write_reg == '0));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    state_d = S_CLEAR;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            S_CLEAR: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == '1) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == S_CLEAR) begin
            regs_q[idx_q] <= '0;
        end else if (wr_en) begin
            regs_q[write_reg] <= write_data;
        end
    end

    function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] val;
        val = regs_q[addr];
`ifdef MIPS_REGFILE_BYPASS_EN
        if (wr_en && (write_reg == addr)) begin
            val = write_data;
        end
`endif
        if ((ZERO_REG != 0) && (addr == '0)) begin
            val = '0;
        end
        return val;
    endfunction

    assign read_data_1 = rd_port(read_reg_1);
    assign read_data_2 = rd_port(read_reg_2);
    assign clear_busy  = busy_q;
    assign clear_done  = done_q;

endmodule

// File: tb/tb_mips_regfile_param.sv
// Testbench for mips_regfile_param: table vectors, corner-case sequences and randomized traffic vs a reference model.
module tb_mips_regfile_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  read_reg_1 = '0, read_reg_2 = '0, write_reg = '0;
    logic [31:0] read_data_1, read_data_2, write_data = '0;
    logic        signal_reg_write = 1'b0, clear_req = 1'b0;
    logic        clear_busy, clear_done;

    int checks = 0;
    int errors = 0;

    // Reference model: contents plus clear progress (mode 0 idle, 1 clearing, 2 done).
    logic [31:0] mem [32];
    int          mmode = 0;
    int          mpos  = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;
    vec_t vecs [5];

    mips_regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_reg_1(read_reg_1), .read_reg_2(read_reg_2),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .write_reg(write_reg), .write_data(write_data),
        .signal_reg_write(signal_reg_write), .clear_req(clear_req),
        .clear_busy(clear_busy), .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mexp(input logic [4:0] a);
        logic [31:0] v;
        v = mem[a];
`ifdef MIPS_REGFILE_BYPASS_EN
        if (signal_reg_write && mmode == 0 && write_reg == a) v = write_data;
`endif
        if (a == 5'd0) v = 32'h0;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mmode = 0;
        mpos  = 0;
    endtask

    task automatic model_edge();
        if (mmode == 0) begin
            if (signal_reg_write && write_reg != 5'd0) mem[write_reg] = write_data;
            if (clear_req) begin
                mmode = 1;
                mpos  = 0;
            end
        end else if (mmode == 1) begin
            mem[mpos] = 32'h0;
            mpos++;
            if (mpos == 32) mmode = 2;
        end else begin
            mmode = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " rd1"}, read_data_1, mexp(read_reg_1));
        chk({tag, " rd2"}, read_data_2, mexp(read_reg_2));
        chk({tag, " busy"}, {31'h0, clear_busy}, {31'h0, mmode == 1});
        chk({tag, " done"}, {31'h0, clear_done}, {31'h0, mmode == 2});
    endtask

    // Drive one cycle's inputs, check before and after the rising edge.
    task automatic step(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2, input logic creq);
        signal_reg_write = we;
        write_reg        = wr;
        write_data       = wd;
        read_reg_1       = a1;
        read_reg_2       = a2;
        clear_req        = creq;
        #1;
        check_outputs("pre");
        @(posedge clk);
        model_edge();
        #1;
        check_outputs("post");
    endtask

    initial begin
        int busy_cnt, done_cnt;
        model_reset();
        vecs[0] = '{1'b1, 5'd3, 32'h0F800000, 5'd3, 5'd1, 32'h0F800000, 32'h0};
        vecs[1] = '{1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd3, 32'h0,        32'h0F800000};
        vecs[2] = '{1'b1, 5'd7, 32'h12345678, 5'd7, 5'd0, 32'h12345678, 32'h0};
        vecs[3] = '{1'b0, 5'd7, 32'h0,        5'd7, 5'd3, 32'h12345678, 32'h0F800000};
        vecs[4] = '{1'b1, 5'd3, 32'h11111111, 5'd3, 5'd7, 32'h11111111, 32'h12345678};

        // Reset state
        read_reg_1 = 5'd3;
        read_reg_2 = 5'd31;
        #2;
        chk("reset busy", {31'h0, clear_busy}, 32'h0);
        chk("reset done", {31'h0, clear_done}, 32'h0);
        chk("reset rd1", read_data_1, 32'h0);
        chk("reset rd2", read_data_2, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors
        for (int i = 0; i < 5; i++) begin
            step(vecs[i].we, vecs[i].wr, vecs[i].wd, vecs[i].a1, vecs[i].a2, 1'b0);
            chk($sformatf("vec%0d rd1", i), read_data_1, vecs[i].e1);
            chk($sformatf("vec%0d rd2", i), read_data_2, vecs[i].e2);
        end

        // Same-cycle write/read of r9
        signal_reg_write = 1'b1;
        write_reg  = 5'd9;
        write_data = 32'h12345678;
        read_reg_1 = 5'd9;
        read_reg_2 = 5'd0;
        #1;
`ifdef MIPS_REGFILE_BYPASS_EN
        chk("bypass pre-edge", read_data_1, 32'h12345678);
`else
        chk("no-bypass pre-edge", read_data_1, 32'h0);
`endif
        step(1'b1, 5'd9, 32'h12345678, 5'd9, 5'd0, 1'b0);
        step(1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 1'b0);
        chk("r9 after edge", read_data_1, 32'h12345678);

        // Fill every register with nonzero data
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 5'(i), 32'hA0000000 | 32'(i * 7 + 1), 5'(i), 5'(31 - i), 1'b0);
        end

        // Full clear, with writes dropped in CLEAR and DONE and a re-request ignored
        busy_cnt = 0;
        done_cnt = 0;
        step(1'b0, 5'd0, 32'h0, 5'd31, 5'd1, 1'b1);
        if (clear_busy) busy_cnt++;
        for (int c = 0; c < 40; c++) begin
            logic we;
            logic rq;
            we = (mmode == 1 && mpos == 2) || (mmode == 2);
            rq = (mmode == 1 && mpos == 5);
            step(we, 5'd31, 32'hAAAA5555, 5'd31, 5'(c), rq);
            if (clear_busy) busy_cnt++;
            if (clear_done) done_cnt++;
        end
        chk("clear busy cycles", busy_cnt, 32);
        chk("clear done cycles", done_cnt, 1);
        for (int i = 0; i < 32; i += 2) begin
            step(1'b0, 5'd0, 32'h0, 5'(i), 5'(i + 1), 1'b0);
            chk($sformatf("cleared r%0d", i), read_data_1, 32'h0);
            chk($sformatf("cleared r%0d", i + 1), read_data_2, 32'h0);
        end
        step(1'b1, 5'd31, 32'hAAAA5555, 5'd2, 5'd1, 1'b0);
        step(1'b0, 5'd0, 32'h0, 5'd31, 5'd1, 1'b0);
        chk("r31 write after done", read_data_1, 32'hAAAA5555);

        // Reset mid-clear
        step(1'b1, 5'd5, 32'h55555555, 5'd5, 5'd31, 1'b0);
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1'b1);
        for (int c = 0; c < 10; c++) step(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("abort busy", {31'h0, clear_busy}, 32'h0);
        chk("abort rd31", read_data_2, 32'h0);
        chk("abort rd5", read_data_1, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("abort no done", {31'h0, clear_done}, 32'h0);
            chk("abort busy held", {31'h0, clear_busy}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1'b1);
        chk("clear after reset", {31'h0, clear_busy}, 32'h1);
        for (int c = 0; c < 33; c++) step(1'b0, 5'd0, 32'h0, 5'(c), 5'd31, 1'b0);
        chk("idle after re-clear", {31'h0, clear_busy | clear_done}, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                 5'($urandom), 5'($urandom), ($urandom_range(0, 59) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_regfile_param.md
# mips_regfile_param

Parametrised MIPS general-purpose register file. It is the next generation of the fixed 32×32 `mips_registers` block, with configurable width and depth, optional hardwired zero register and asynchronous reset. It adds a sequential clear engine that zeroes the whole file one entry per cycle on request, with a busy/done handshake. It sits in the decode stage: two combinational read ports feed the ALU operand muxes, and one synchronous write port is driven from write-back.

## Interface
- `DATA_W`, default 32: register width in bits.
- `ADDR_W`, default 5: address width. Depth is `NUM_REGS = 2**ADDR_W`.
- `ZERO_REG`, default 1: when 1, register 0 is hardwired to zero.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `read_reg_1`  in  ADDR_W  read port 1 address.
- `read_reg_2`  in  ADDR_W  read port 2 address.
- `read_data_1`  out  DATA_W  read port 1 data, combinational.
- `read_data_2`  out  DATA_W  read port 2 data, combinational.
- `write_reg`  in  ADDR_W  write address.
- `write_data`  in  DATA_W  write data.
- `signal_reg_write`  in  1  write enable.
- `clear_req`  in  1  request a full clear; level-sampled on the rising edge.
- `clear_busy`  out  1  clear sequence in progress.
- `clear_done`  out  1  one-cycle pulse when the clear completes.

## Operation
- Reads are combinational: `read_data_n = regs[read_reg_n]`, subject to the zero and bypass rules below.
- Write: on the rising edge, if `signal_reg_write=1` and the state is IDLE, `regs[write_reg] <= write_data`.
- With `ZERO_REG=1`:
  - writes to address 0 are discarded;
  - reads of address 0 return 0 regardless of bypass.
- Clear FSM states are IDLE, CLEAR and DONE.
  - IDLE → CLEAR when `clear_req=1` at an edge. The index resets to 0.
  - In CLEAR, each edge does `regs[idx] <= 0` and `idx <= idx+1`.
  - After clearing index NUM_REGS−1 the FSM goes to DONE. The index is ADDR_W bits wide and wraps to 0 there.
  - DONE → IDLE unconditionally after one cycle.
- Outputs by state:
  - `clear_busy=1` in CLEAR only.
  - `clear_done=1` in DONE only.
- Boundary rules:
  - `clear_req` while in CLEAR or DONE is ignored. No queuing.
  - `signal_reg_write` in CLEAR or DONE is dropped silently, including in the DONE cycle.
  - Reads during CLEAR return the current contents: already-cleared entries read 0, the rest read their old values.
  - `clear_req` and `signal_reg_write` together in IDLE: the write commits at that edge, and the clear starts at the same edge and overwrites it later.
  - Read address equal to write address with no bypass: the read returns the old value until the edge.
- Reset (`rst_n=0`) sets all registers to 0, state to IDLE, idx to 0, `clear_busy=0` and `clear_done=0`. It applies at any time, including mid-clear, where the sequence is aborted with no `clear_done` pulse.

## Timing
- Write-to-read latency is 1 edge when bypass is off and 0 cycles when bypass is on.
- Clear latency with `clear_req` sampled at edge k:
  - `clear_busy` is high from edge k to edge k+NUM_REGS, i.e. exactly NUM_REGS cycles;
  - register i is zeroed at edge k+1+i;
  - `clear_done` is high from edge k+NUM_REGS to edge k+NUM_REGS+1;
  - IDLE is re-entered at edge k+NUM_REGS+1, and a new `clear_req` is accepted from that edge.
- Reset is asynchronous. Outputs take their reset values without waiting for `clk`, and release is synchronous to the next edge.

## Configuration
- `MIPS_REGFILE_BYPASS_EN` defined: write-through forwarding. When `signal_reg_write=1`, the state is IDLE, `write_reg==read_reg_n`, and the address is not zero-hardwired, then `read_data_n = write_data` in the same cycle.
- Undefined: no forwarding. Reads always return stored contents.

## Test plan
- Basic write/read: reset, write 0x0F800000 to r3, then read r3 and r1 → `read_data_1=0x0F800000` and `read_data_2=0` after the edge.
- Zero register: write 0xDEADBEEF to r0 (`ZERO_REG=1`) → r0 reads 0 both before and after the edge, even with bypass defined.
- Bypass: write 0x12345678 to r7 and read r7 in the same cycle → data appears before the edge when `MIPS_REGFILE_BYPASS_EN` is defined, and only after the edge when it is not.
- Clear sequence (`ADDR_W=5`): fill all 32 registers with nonzero values, pulse `clear_req` → `clear_busy` high for exactly 32 cycles, `clear_done` high for 1 cycle, all registers read 0 afterwards.
- Write during clear: issue a write of 0xAAAA5555 to r31 in the 3rd cycle of CLEAR and another in the DONE cycle → both dropped, r31 reads 0 after DONE. A write issued one cycle after DONE commits.
- Reset mid-clear: assert `rst_n=0` asynchronously midway through CLEAR → `clear_busy` falls immediately, no `clear_done` pulse, all registers read 0, and a new `clear_req` after release is accepted.
